lap_timer: RTL and testbench

Parametrised successor to the team's `stopwatch`: an h/m/s elapsed-time counter advanced by an external tick strobe. It adds a configurable tick prescaler and hour wrap, synchronous clear, and a lap-capture FIFO with a valid/ready read port. Optionally, it adds a preset countdown mode. It sits between the board's 1 Hz/kHz strobe generator and the display/UART reporting logic.

---
 rtl/lap_timer.sv | 212 +++++++++++++++++++++
 tb/tb_lap_timer.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lap_timer.sv
// lap_timer: h/m/s elapsed-time counter advanced by an external tick strobe,
// with tick prescaler, hour wrap, synchronous clear and a lap-capture FIFO
// read through a valid/ready port.
// Optional preset/countdown mode is compiled in when LAP_TIMER_COUNTDOWN_EN
// is defined; otherwise down/load/load_* are ignored and expired stays 0.
module lap_timer #(
  parameter int TICK_DIV  = 1,
  parameter int HOURS_MAX = 23,
  parameter int LAP_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       start,
  input  logic       clear,
  input  logic       lap,
  input  logic       down,
  input  logic       load,
  input  logic [5:0] load_hours,
  input  logic [5:0] load_minutes,
  input  logic [5:0] load_seconds,
  output logic [5:0] hours,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic       running,
  output logic       expired,
  output logic       lap_valid,
  input  logic       lap_ready,
  output logic [5:0] lap_hours,
  output logic [5:0] lap_minutes,
  output logic [5:0] lap_seconds,
  output logic       lap_overflow
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int AW = $clog2(LAP_DEPTH);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [5:0]    HMAX       = 6'(HOURS_MAX);
  localparam logic [AW:0]   DEPTH      = (AW+1)'(LAP_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  state_t        state_q, state_d;
  logic          start_q, lap_q;
  logic          start_ev, lap_ev;
  logic [PW-1:0] presc_q;
  logic          cd_down, cd_load;
  logic          zero, one, tick, step_ok, expire_now;
  logic [5:0]    hrs_d, min_d, sec_d;

  logic [17:0]   mem [LAP_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, push, pop;

  function automatic logic [5:0] sat_59(input logic [5:0] v);
    return (v > 6'd59) ? 6'd59 : v;
  endfunction

  function automatic logic [5:0] sat_hours(input logic [5:0] v);
    return (v > HMAX) ? HMAX : v;
  endfunction

`ifdef LAP_TIMER_COUNTDOWN_EN
  assign cd_down = down;
  assign cd_load = load & (state_q != RUN);
`else
  logic unused_cd;
  assign unused_cd = ^{down, load};
  assign cd_down   = 1'b0;
  assign cd_load   = 1'b0;
`endif

  assign start_ev   = start & ~start_q;
  assign lap_ev     = lap & ~lap_q;
  assign zero       = (hours == 6'd0) && (minutes == 6'd0) && (seconds == 6'd0);
  assign one        = (hours == 6'd0) && (minutes == 6'd0) && (seconds == 6'd1);
  // The tick looks at the pre-toggle state, so a start event never gates it.
  assign tick       = (state_q == RUN) & en & (presc_q == PRESC_LAST) & ~clear;
  assign step_ok    = tick & ~(cd_down & zero);
  assign expire_now = tick & cd_down & one;
  assign running    = (state_q == RUN);

  // Edge-detect history for start and lap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      start_q <= 1'b0;
      lap_q   <= 1'b0;
    end else begin
      start_q <= start;
      lap_q   <= lap;
    end
  end

  // Run-state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state: clear, then load, then start toggle, then countdown expiry.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else if (cd_load) begin
      state_d = PAUSE;
    end else if (start_ev) begin
      if (state_q == RUN)        state_d = PAUSE;
      else if (!(cd_down && zero)) state_d = RUN;
    end else if (expire_now) begin
      state_d = PAUSE;
    end
  end

  // Prescaler keeps its count across pause; only clear/load/reset zero it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                      presc_q <= '0;
    else if (clear || cd_load)      presc_q <= '0;
    else if (state_q == RUN && en)  presc_q <= (presc_q == PRESC_LAST) ? '0 : presc_q + 1'b1;
  end

  // One-second step value: carry chain up, borrow chain down.
  always_comb begin
    sec_d = seconds;
    min_d = minutes;
    hrs_d = hours;
    if (cd_down) begin
      if (seconds != 6'd0) begin
        sec_d = seconds - 1'b1;
      end else begin
        sec_d = 6'd59;
        if (minutes != 6'd0) begin
          min_d = minutes - 1'b1;
        end else begin
          min_d = 6'd59;
          hrs_d = (hours == 6'd0) ? HMAX : hours - 1'b1;
        end
      end
    end else begin
      if (seconds != 6'd59) begin
        sec_d = seconds + 1'b1;
      end else begin
        sec_d = 6'd0;
        if (minutes != 6'd59) begin
          min_d = minutes + 1'b1;
        end else begin
          min_d = 6'd0;
          hrs_d = (hours == HMAX) ? 6'd0 : hours + 1'b1;
        end
      end
    end
  end

  // Displayed time and the registered expiry pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hours   <= '0;
      minutes <= '0;
      seconds <= '0;
      expired <= 1'b0;
    end else begin
      expired <= expire_now;
      if (clear) begin
        hours   <= '0;
        minutes <= '0;
        seconds <= '0;
      end else if (cd_load) begin
        hours   <= sat_hours(load_hours);
        minutes <= sat_59(load_minutes);
        seconds <= sat_59(load_seconds);
      end else if (step_ok) begin
        hours   <= hrs_d;
        minutes <= min_d;
        seconds <= sec_d;
      end
    end
  end

  assign lap_valid = (count != '0);
  assign full      = (count == DEPTH);
  assign pop       = lap_valid & lap_ready;
  // A push on full still goes in when the head leaves in the same cycle.
  assign push      = lap_ev & (~full | pop);
  assign {lap_hours, lap_minutes, lap_seconds} = mem[rd_ptr];

  // Lap FIFO: captures the registered (pre-step) time on each lap event.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      lap_overflow <= 1'b0;
      for (int i = 0; i < LAP_DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      lap_overflow <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {hours, minutes, seconds};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (lap_ev && full && !pop) lap_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_lap_timer.sv
// Bench for lap_timer: two instances (TICK_DIV=1/HOURS_MAX=23 and
// TICK_DIV=4/HOURS_MAX=1) share stimulus; a time-in-seconds model tracks both.
module tb_lap_timer;
`ifdef LAP_TIMER_COUNTDOWN_EN
  localparam bit CD = 1'b1;
`else
  localparam bit CD = 1'b0;
`endif
  localparam int DEPTH = 4;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, en, start, clear, lap, down, load, lap_ready;
  logic [5:0] load_hours, load_minutes, load_seconds;
  logic [5:0] hrs [2], mins [2], secs [2], lhrs [2], lmins [2], lsecs [2];
  logic       run [2], expd [2], lvld [2], lovf [2];

  lap_timer #(.TICK_DIV(1), .HOURS_MAX(23), .LAP_DEPTH(DEPTH)) u_div1 (
    .clk(clk), .reset(reset), .en(en), .start(start), .clear(clear), .lap(lap),
    .down(down), .load(load), .load_hours(load_hours), .load_minutes(load_minutes),
    .load_seconds(load_seconds), .hours(hrs[0]), .minutes(mins[0]), .seconds(secs[0]),
    .running(run[0]), .expired(expd[0]), .lap_valid(lvld[0]), .lap_ready(lap_ready),
    .lap_hours(lhrs[0]), .lap_minutes(lmins[0]), .lap_seconds(lsecs[0]),
    .lap_overflow(lovf[0]));

  lap_timer #(.TICK_DIV(4), .HOURS_MAX(1), .LAP_DEPTH(DEPTH)) u_div4 (
    .clk(clk), .reset(reset), .en(en), .start(start), .clear(clear), .lap(lap),
    .down(down), .load(load), .load_hours(load_hours), .load_minutes(load_minutes),
    .load_seconds(load_seconds), .hours(hrs[1]), .minutes(mins[1]), .seconds(secs[1]),
    .running(run[1]), .expired(expd[1]), .lap_valid(lvld[1]), .lap_ready(lap_ready),
    .lap_hours(lhrs[1]), .lap_minutes(lmins[1]), .lap_seconds(lsecs[1]),
    .lap_overflow(lovf[1]));

  int nvec = 0;
  int nmis = 0;

  // Reference model: elapsed time as total seconds, FIFO as a plain list.
  int mt [2], mst [2], macc [2], mex [2], movf [2], mqn [2];
  int mq [2][16];
  bit msq, mlq;

  function automatic int div_of(int k);
    return (k == 0) ? 1 : 4;
  endfunction
  function automatic int hmax_of(int k);
    return (k == 0) ? 23 : 1;
  endfunction
  function automatic int sat(int v, int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic chk(string nm, int act, int exp);
    nvec++;
    if (act != exp) begin
      nmis++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mt[k] = 0; mst[k] = M_IDLE; macc[k] = 0; mex[k] = 0; movf[k] = 0; mqn[k] = 0;
    end
    msq = 1'b0;
    mlq = 1'b0;
  endtask

  task automatic model_step();
    bit sev, lev, pop, full;
    int nst;
    sev = start && !msq;
    lev = lap && !mlq;
    for (int k = 0; k < 2; k++) begin
      pop  = (mqn[k] > 0) && lap_ready;
      full = (mqn[k] == DEPTH);
      mex[k] = 0;
      if (clear) begin
        mt[k] = 0; mst[k] = M_IDLE; macc[k] = 0; mqn[k] = 0; movf[k] = 0;
      end else begin
        if (pop) begin
          for (int i = 0; i < 15; i++) mq[k][i] = mq[k][i+1];
          mqn[k]--;
        end
        if (lev) begin
          if (!full || pop) begin
            mq[k][mqn[k]] = mt[k];
            mqn[k]++;
          end else begin
            movf[k] = 1;
          end
        end
        if (CD && load && mst[k] != M_RUN) begin
          mt[k]   = sat(load_hours, hmax_of(k)) * 3600 + sat(load_minutes, 59) * 60
                    + sat(load_seconds, 59);
          mst[k]  = M_PAUSE;
          macc[k] = 0;
        end else begin
          nst = mst[k];
          if (sev) begin
            if (mst[k] == M_RUN) nst = M_PAUSE;
            else if (!(CD && down && mt[k] == 0)) nst = M_RUN;
          end
          if (mst[k] == M_RUN && en) begin
            macc[k]++;
            if (macc[k] == div_of(k)) begin
              macc[k] = 0;
              if (CD && down) begin
                if (mt[k] > 0) begin
                  mt[k]--;
                  if (mt[k] == 0) begin
                    mex[k] = 1;
                    nst = M_PAUSE;
                  end
                end
              end else begin
                mt[k] = (mt[k] + 1) % ((hmax_of(k) + 1) * 3600);
              end
            end
          end
          mst[k] = nst;
        end
      end
    end
    msq = start;
    mlq = lap;
  endtask

  task automatic check_all(string tag);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s.u%0d.hours", tag, k), hrs[k], mt[k] / 3600);
      chk($sformatf("%s.u%0d.minutes", tag, k), mins[k], (mt[k] / 60) % 60);
      chk($sformatf("%s.u%0d.seconds", tag, k), secs[k], mt[k] % 60);
      chk($sformatf("%s.u%0d.running", tag, k), run[k], (mst[k] == M_RUN) ? 1 : 0);
      chk($sformatf("%s.u%0d.expired", tag, k), expd[k], mex[k]);
      chk($sformatf("%s.u%0d.lap_valid", tag, k), lvld[k], (mqn[k] > 0) ? 1 : 0);
      chk($sformatf("%s.u%0d.lap_overflow", tag, k), lovf[k], movf[k]);
      if (mqn[k] > 0) begin
        chk($sformatf("%s.u%0d.lap_hours", tag, k), lhrs[k], mq[k][0] / 3600);
        chk($sformatf("%s.u%0d.lap_minutes", tag, k), lmins[k], (mq[k][0] / 60) % 60);
        chk($sformatf("%s.u%0d.lap_seconds", tag, k), lsecs[k], mq[k][0] % 60);
      end
    end
  endtask

  task automatic check_reset(string tag);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s.u%0d.time", tag, k), {hrs[k], mins[k], secs[k]}, 0);
      chk($sformatf("%s.u%0d.flags", tag, k), {run[k], expd[k], lvld[k], lovf[k]}, 0);
      chk($sformatf("%s.u%0d.lapdata", tag, k), {lhrs[k], lmins[k], lsecs[k]}, 0);
    end
  endtask

  // One clock: model follows the edge, outputs are compared 1 unit later.
  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    check_all("cyc");
  endtask

  typedef struct {
    int rep;
    bit st, en, clr, lp, rdy;
    int eh, em, es;
    bit erun, elv;
    int els;
    bit eovf;
  } vec_t;

  function automatic vec_t mkv(int rep, bit st, bit e, bit c, bit l, bit r,
                               int eh, int em, int es, bit erun, bit elv, int els, bit eovf);
    vec_t v;
    v.rep = rep; v.st = st; v.en = e; v.clr = c; v.lp = l; v.rdy = r;
    v.eh = eh; v.em = em; v.es = es; v.erun = erun; v.elv = elv; v.els = els; v.eovf = eovf;
    return v;
  endfunction

  vec_t tbl [$];

  initial begin
    //            rep st en cl lp rd  h  m  s  run lv ls ovf   (checks TICK_DIV=1 instance)
    tbl.push_back(mkv( 1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0));
    tbl.push_back(mkv( 1, 1, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 0));
    tbl.push_back(mkv( 5, 1, 1, 0, 0, 0, 0, 0,  5, 1, 0, 0, 0));
    tbl.push_back(mkv( 1, 0, 0, 0, 0, 0, 0, 0,  5, 1, 0, 0, 0));
    tbl.push_back(mkv( 1, 1, 0, 0, 0, 0, 0, 0,  5, 0, 0, 0, 0));
    tbl.push_back(mkv(10, 0, 0, 0, 0, 0, 0, 0,  5, 0, 0, 0, 0));
    tbl.push_back(mkv( 1, 1, 0, 0, 0, 0, 0, 0,  5, 1, 0, 0, 0));
    tbl.push_back(mkv(65, 0, 1, 0, 0, 0, 0, 1, 10, 1, 0, 0, 0));
    tbl.push_back(mkv( 1, 0, 0, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0));
    tbl.push_back(mkv( 1, 1, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 0));
    for (int t = 1; t <= 5; t++) begin
      tbl.push_back(mkv(1, 0, 1, 0, 0, 0, 0, 0, t, 1, t > 1, 1, 0));
      tbl.push_back(mkv(1, 0, 0, 0, 1, 0, 0, 0, t, 1, 1, 1, t == 5));
    end
    tbl.push_back(mkv( 1, 0, 0, 0, 0, 0, 0, 0,  5, 1, 1, 1, 1));
    tbl.push_back(mkv( 1, 0, 0, 0, 0, 1, 0, 0,  5, 1, 1, 2, 1));
    tbl.push_back(mkv( 1, 0, 0, 0, 0, 1, 0, 0,  5, 1, 1, 3, 1));
    tbl.push_back(mkv( 1, 0, 0, 0, 0, 1, 0, 0,  5, 1, 1, 4, 1));
    tbl.push_back(mkv( 1, 0, 0, 0, 0, 1, 0, 0,  5, 1, 0, 0, 1));
    tbl.push_back(mkv( 4, 0, 1, 0, 0, 0, 0, 0,  9, 1, 0, 0, 1));
    tbl.push_back(mkv( 1, 0, 1, 0, 1, 0, 0, 0, 10, 1, 1, 9, 1));
    tbl.push_back(mkv( 1, 0, 0, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0));

    reset = 1'b1; en = 0; start = 0; clear = 0; lap = 0; down = 0; load = 0; lap_ready = 0;
    load_hours = 0; load_minutes = 0; load_seconds = 0;
    model_reset();
    #3;
    check_reset("reset");
    #4;
    reset = 1'b0;

    foreach (tbl[i]) begin
      start = tbl[i].st; en = tbl[i].en; clear = tbl[i].clr;
      lap = tbl[i].lp; lap_ready = tbl[i].rdy;
      repeat (tbl[i].rep) cyc();
      chk($sformatf("vec%0d.hours", i), hrs[0], tbl[i].eh);
      chk($sformatf("vec%0d.minutes", i), mins[0], tbl[i].em);
      chk($sformatf("vec%0d.seconds", i), secs[0], tbl[i].es);
      chk($sformatf("vec%0d.running", i), run[0], tbl[i].erun);
      chk($sformatf("vec%0d.lap_valid", i), lvld[0], tbl[i].elv);
      chk($sformatf("vec%0d.lap_overflow", i), lovf[0], tbl[i].eovf);
      if (tbl[i].elv) chk($sformatf("vec%0d.lap_seconds", i), lsecs[0], tbl[i].els);
    end
    start = 0; en = 0; clear = 0; lap = 0; lap_ready = 0;

    // Prescaler by 4: 8 strobes -> 2 s, 3 more held across a pause, 1 more -> 3 s.
    start = 1; cyc(); start = 0;
    en = 1; repeat (8) cyc();
    chk("div4.after8", {hrs[1], mins[1], secs[1]}, 2);
    chk("div4.run", run[1], 1);
    repeat (3) cyc();
    chk("div4.after11", secs[1], 2);
    en = 0; start = 1; cyc(); start = 0; cyc();
    chk("div4.paused", run[1], 0);
    start = 1; cyc(); start = 0;
    chk("div4.resumed", run[1], 1);
    en = 1; cyc(); en = 0;
    chk("div4.after12", {hrs[1], mins[1], secs[1]}, 3);

    clear = 1; cyc(); clear = 0;
    if (CD) begin
      load_hours = 23; load_minutes = 59; load_seconds = 59; load = 1; cyc(); load = 0;
      chk("cd.load_max", {hrs[0], mins[0], secs[0]}, {6'd23, 6'd59, 6'd59});
      chk("cd.load_paused", run[0], 0);
      start = 1; cyc(); start = 0;
      en = 1; cyc(); en = 0;
      chk("cd.hour_wrap", {hrs[0], mins[0], secs[0]}, 0);
      start = 1; cyc(); start = 0;
      load_hours = 0; load_minutes = 0; load_seconds = 75; load = 1; cyc(); load = 0;
      chk("cd.load_sat", {hrs[0], mins[0], secs[0]}, 59);
      down = 1; load_seconds = 2; load = 1; cyc(); load = 0;
      start = 1; cyc(); start = 0;
      chk("cd.run", run[0], 1);
      en = 1; cyc();
      chk("cd.at1", {secs[0], expd[0]}, {6'd1, 1'b0});
      cyc();
      chk("cd.expire", {hrs[0], mins[0], secs[0], expd[0], run[0]}, {18'd0, 1'b1, 1'b0});
      cyc(); en = 0;
      chk("cd.after_expire", {secs[0], expd[0]}, 0);
      start = 1; cyc(); start = 0; cyc();
      chk("cd.start_ignored", run[0], 0);
      down = 0;
    end else begin
      load_hours = 23; load_minutes = 59; load_seconds = 59; load = 1; cyc(); load = 0;
      chk("nocd.load_ignored", {hrs[0], mins[0], secs[0], run[0]}, 0);
      start = 1; cyc(); start = 0;
      down = 1; en = 1; cyc(); en = 0; down = 0;
      chk("nocd.counts_up", {hrs[0], mins[0], secs[0], expd[0]}, {6'd0, 6'd0, 6'd1, 1'b0});
    end

    // Asynchronous reset mid-operation with a lap queued.
    clear = 1; cyc(); clear = 0;
    start = 1; cyc(); start = 0;
    en = 1; repeat (3) cyc();
    lap = 1; cyc(); lap = 0; en = 0;
    chk("arst.pre_lap_valid", lvld[0], 1);
    reset = 1'b1;
    #2;
    model_reset();
    check_reset("arst");
    reset = 1'b0;

    // Randomised traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      start     = ($urandom_range(0, 7) == 0);
      en        = $urandom_range(0, 1);
      clear     = ($urandom_range(0, 99) == 0);
      lap       = ($urandom_range(0, 3) == 0);
      lap_ready = ($urandom_range(0, 2) == 0);
      load      = ($urandom_range(0, 49) == 0);
      load_hours   = 6'($urandom_range(0, 63));
      load_minutes = 6'($urandom_range(0, 63));
      load_seconds = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 99) == 0) down = ~down;
      cyc();
    end

    // Long run to push the HOURS_MAX=1 instance through its hour wrap.
    start = 0; en = 0; lap = 0; lap_ready = 0; load = 0; down = 0;
    clear = 1; cyc(); clear = 0;
    start = 1; cyc(); start = 0;
    en = 1; repeat (29000) cyc(); en = 0;
    chk("long.div1", {hrs[0], mins[0], secs[0]}, {6'd8, 6'd3, 6'd20});
    chk("long.div4_wrapped", {hrs[1], mins[1], secs[1]}, {6'd0, 6'd0, 6'd50});

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
